// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Purpose:
//   Sequences a PLL out of reset, waits for it to report lock, and checks that
//   the lock stays solid for a while before releasing the downstream reset.
//   Each lock attempt that times out is counted. After MAX_RETRY failed attempts
//   the block parks in FAULT until it sees a restart request. All outputs are
//   registered on refclk.
//
// Parameters:
//   RST_CYCLES    - cycles pll_rst is held high per attempt (1..65535)
//   LOCK_TIMEOUT  - cycles allowed for lock before the attempt fails (1..65535)
//   STABLE_CYCLES - consecutive locked cycles required before release (1..65535)
//   MAX_RETRY     - failed attempts that lead to FAULT (1..15)
//
// Ports:
//   refclk     in   single clock, all logic on its rising edge
//   rst_n      in   synchronous active-low reset
//   pll_locked in   PLL lock indication, asynchronous to refclk
//   restart    in   one-cycle request to re-sequence the PLL
//   pll_rst    out  PLL reset, active-high
//   sys_rst_n  out  downstream synchronous reset, active-low (high only in RUN)
//   ready      out  high only in RUN
//   fault      out  high only in FAULT
//   state      out  current state code (0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE,
//                   3 RUN, 4 FAULT)
//   loss_cnt   out  8-bit saturating count of lock losses seen in RUN
//                   (present only when PLL_SUP_STATUS_EN is defined)
//
// Build option:
//   PLL_SUP_STATUS_EN - adds the loss_cnt status output.

module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRY     = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
`ifdef PLL_SUP_STATUS_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } stateE;

  // Terminal counts are precomputed so each state compares against a constant.
  localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRY);

  stateE       state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        syncStage1_q, lockS_q;
  logic        pllRst_q, pllRst_d;
  logic        sysRstN_q, sysRstN_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;

  // State, counter, retry count, synchronizer and registered outputs. The
  // FSM only ever looks at lockS_q, the second synchronizer stage.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state_q      <= RESET_PLL;
      cnt_q        <= 16'd0;
      retry_q      <= 4'd0;
      syncStage1_q <= 1'b0;
      lockS_q      <= 1'b0;
      pllRst_q     <= 1'b1;
      sysRstN_q    <= 1'b0;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      syncStage1_q <= pll_locked;
      lockS_q      <= syncStage1_q;
      pllRst_q     <= pllRst_d;
      sysRstN_q    <= sysRstN_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  // Next-state logic. Restart wins over every other transition. The output
  // registers are loaded from the next state, so they change on the same
  // edge that the state changes.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;

    if (restart) begin
      state_d = RESET_PLL;
      retry_d = 4'd0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lockS_q) begin
            state_d = STABLE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + 4'd1;
            state_d = (retry_d == RETRY_LIMIT) ? FAULT : RESET_PLL;
          end
        end
        STABLE: begin
          if (!lockS_q) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            retry_d = 4'd0;
          end
        end
        RUN: begin
          if (!lockS_q) state_d = RESET_PLL;
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_PLL;
        end
      endcase
    end

    // One counter is shared by every timed state. It restarts from zero on
    // any state change (and on restart) and idles in RUN and FAULT.
    if (restart || (state_d != state_q)) begin
      cnt_d = 16'd0;
    end else if (state_q == RESET_PLL || state_q == WAIT_LOCK || state_q == STABLE) begin
      cnt_d = cnt_q + 16'd1;
    end

    pllRst_d  = (state_d == RESET_PLL) || (state_d == FAULT);
    sysRstN_d = (state_d == RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  assign pll_rst   = pllRst_q;
  assign sys_rst_n = sysRstN_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign state     = state_q;

`ifdef PLL_SUP_STATUS_EN
  logic [7:0] lossCnt_q;

  // Counts RUN -> RESET_PLL lock-loss exits only. A restart in the same cycle
  // takes priority, so that cycle is not counted. Only rst_n clears the count.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      lossCnt_q <= 8'd0;
    end else if (!restart && state_q == RUN && !lockS_q && lossCnt_q != 8'hFF) begin
      lossCnt_q <= lossCnt_q + 8'd1;
    end
  end

  assign loss_cnt = lossCnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//
// Each applied cycle pushes the outputs expected after that edge into a queue.
// The reference model steps the supervisor's rules one edge at a time. A
// monitor running on the falling edge pops each entry and compares it with
// the DUT. Directed scenarios add timing checks against hand-derived edge
// numbers. A randomized phase then follows.

module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAULT  = 4;

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       restart    = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [2:0] state;
  logic [7:0] lossAct;

  always #5 refclk = ~refclk;

`ifdef PLL_SUP_STATUS_EN
  logic [7:0] loss_cnt;
  assign lossAct = loss_cnt;
`else
  assign lossAct = 8'd0;
`endif

  pll_lock_supervisor #(
    .RST_CYCLES(RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .sys_rst_n(sys_rst_n),
    .ready(ready),
    .fault(fault),
    .state(state)
`ifdef PLL_SUP_STATUS_EN
    ,
    .loss_cnt(loss_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pllRst;
    logic       sysRstN;
    logic       rdy;
    logic       flt;
    logic [7:0] loss;
  } expT;

  expT expQ[$];
  int  tests  = 0;
  int  failed = 0;

  // Reference model. mCnt is the number of edges already spent in the current
  // phase. pll_locked reaches the decision logic two samples late.
  int mPhase = P_RESET;
  int mCnt   = 0;
  int mRetry = 0;
  int mLoss  = 0;
  bit seen1  = 1'b0;
  bit seen2  = 1'b0;

  function automatic void enterPhase(int p);
    mPhase = p;
    mCnt   = 0;
  endfunction

  function automatic void modelStep(bit rn, bit rs, bit lk);
    bit lockS;
    if (!rn) begin
      enterPhase(P_RESET);
      mRetry = 0;
      mLoss  = 0;
      seen1  = 1'b0;
      seen2  = 1'b0;
      return;
    end
    lockS = seen2;
    seen2 = seen1;
    seen1 = lk;
    if (rs) begin
      enterPhase(P_RESET);
      mRetry = 0;
      return;
    end
    if (mPhase == P_RESET) begin
      if (mCnt + 1 >= RST_CYCLES) enterPhase(P_WAIT); else mCnt++;
    end else if (mPhase == P_WAIT) begin
      if (lockS) enterPhase(P_STABLE);
      else if (mCnt + 1 >= LOCK_TIMEOUT) begin
        mRetry++;
        enterPhase((mRetry == MAX_RETRY) ? P_FAULT : P_RESET);
      end else mCnt++;
    end else if (mPhase == P_STABLE) begin
      if (!lockS) enterPhase(P_WAIT);
      else if (mCnt + 1 >= STABLE_CYCLES) begin
        enterPhase(P_RUN);
        mRetry = 0;
      end else mCnt++;
    end else if (mPhase == P_RUN) begin
      if (!lockS) begin
        enterPhase(P_RESET);
        if (mLoss < 255) mLoss++;
      end
    end
  endfunction

  function automatic expT modelOutputs();
    expT e;
    e.st      = 3'(mPhase);
    e.pllRst  = (mPhase == P_RESET) || (mPhase == P_FAULT);
    e.sysRstN = (mPhase == P_RUN);
    e.rdy     = (mPhase == P_RUN);
    e.flt     = (mPhase == P_FAULT);
`ifdef PLL_SUP_STATUS_EN
    e.loss    = 8'(mLoss);
`else
    e.loss    = 8'd0;
`endif
    return e;
  endfunction

  task automatic applyStimulus(input bit rn, input bit rs, input bit lk);
    @(negedge refclk);
    rst_n      = rn;
    restart    = rs;
    pll_locked = lk;
    @(posedge refclk);
    modelStep(rn, rs, lk);
    expQ.push_back(modelOutputs());
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: one expected entry per applied edge, compared away
  // from the rising edge.
  always @(negedge refclk) begin
    expT e;
    expT a;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      a = {state, pll_rst, sys_rst_n, ready, fault, lossAct};
      tests++;
      if (a !== e) begin
        failed++;
        $display("[TB] FAIL scoreboard @%0t: state %0d/%0d pll_rst %b/%b sys_rst_n %b/%b ready %b/%b fault %b/%b loss %0d/%0d (got/expected)",
                 $time, a.st, e.st, a.pllRst, e.pllRst, a.sysRstN, e.sysRstN,
                 a.rdy, e.rdy, a.flt, e.flt, a.loss, e.loss);
      end
    end
  end

  // Watchdog so the run always ends even if something stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  riseEdge;
    int  fallEdge;
    bit  found;
    int  holdLeft;
    bit  lk;
    bit  rs;
    bit  rn;

    // Reset release, lock from cycle 6, lock-to-release latency
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("resetState", int'(state), P_RESET);
    checkOutput("resetPllRst", int'(pll_rst), 1);
    checkOutput("resetSysRstN", int'(sys_rst_n), 0);
    checkOutput("resetReady", int'(ready), 0);
    checkOutput("resetFault", int'(fault), 0);
    riseEdge = -1;
    for (int e = 0; e < 30; e++) begin
      applyStimulus(1'b1, 1'b0, e >= 6);
      #1;
      if (e == 2) checkOutput("pllRstHeldFullCount", int'(pll_rst), 1);
      if (e == 3) checkOutput("pllRstLowInWait", int'(pll_rst), 0);
      if (riseEdge < 0 && sys_rst_n === 1'b1) riseEdge = e;
    end
    checkOutput("lockToReleaseEdge", riseEdge, 16);
    checkOutput("readyInRun", int'(ready), 1);

    // One-cycle lock drop in RUN, then re-lock
    fallEdge = -1;
    for (int e = 0; e < 25; e++) begin
      applyStimulus(1'b1, 1'b0, e != 0);
      #1;
      if (fallEdge < 0 && sys_rst_n === 1'b0) fallEdge = e;
    end
    checkOutput("dropToSysRstEdge", fallEdge, 2);
    checkOutput("relockRun", int'(state), P_RUN);
`ifdef PLL_SUP_STATUS_EN
    checkOutput("lossCntAfterDrop", int'(loss_cnt), 1);
`endif

    // rst_n pulsed for one cycle mid-RUN; the full sequence repeats
    applyStimulus(1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("midRunResetState", int'(state), P_RESET);
    checkOutput("midRunResetPllRst", int'(pll_rst), 1);
    checkOutput("midRunResetSysRstN", int'(sys_rst_n), 0);
    checkOutput("midRunResetReady", int'(ready), 0);
    checkOutput("midRunResetFault", int'(fault), 0);
    riseEdge = -1;
    for (int e = 0; e < 30; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      #1;
      if (riseEdge < 0 && sys_rst_n === 1'b1) riseEdge = e;
    end
    checkOutput("rerunReleaseEdge", riseEdge, 12);
`ifdef PLL_SUP_STATUS_EN
    checkOutput("lossCntClearedByRst", int'(loss_cnt), 0);
`endif

    // No lock at all: two timeouts lead to FAULT; restart leaves it
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 60; e++) applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("faultState", int'(state), P_FAULT);
    checkOutput("faultFlag", int'(fault), 1);
    checkOutput("faultPllRst", int'(pll_rst), 1);
    checkOutput("faultSysRstN", int'(sys_rst_n), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("restartFromFaultState", int'(state), P_RESET);
    checkOutput("restartFromFaultFlag", int'(fault), 0);

    // Lock glitch while STABLE holds count 5: back to WAIT_LOCK, full recount
    applyStimulus(1'b1, 1'b1, 1'b0);
    riseEdge = -1;
    for (int e = 1; e <= 40; e++) begin
      applyStimulus(1'b1, 1'b0, (e >= 7) && (e != 13));
      #1;
      if (e == 14) checkOutput("stableBeforeGlitch", int'(state), P_STABLE);
      if (e == 15) checkOutput("glitchBackToWait", int'(state), P_WAIT);
      if (riseEdge < 0 && sys_rst_n === 1'b1) riseEdge = e;
    end
    checkOutput("glitchReleaseEdge", riseEdge, 24);

    // Restart lands on the same edge as the final timeout
    applyStimulus(1'b1, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mPhase == P_WAIT && mCnt == LOCK_TIMEOUT - 1 && mRetry == MAX_RETRY - 1) found = 1'b1;
      else applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("finalTimeoutReached", int'(found), 1);
    #1;
    checkOutput("waitBeforeFinalTimeout", int'(state), P_WAIT);
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("restartBeatsTimeoutState", int'(state), P_RESET);
    checkOutput("restartBeatsTimeoutFault", int'(fault), 0);
    for (int e = 1; e <= 48; e++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      #1;
      if (e == 47) checkOutput("retryClearedNoEarlyFault", int'(fault), 0);
      if (e == 48) checkOutput("retryClearedFaultOnTime", int'(fault), 1);
    end

    // Randomized phase: lock held in runs, occasional restart and reset
    holdLeft = 0;
    lk       = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (holdLeft == 0) begin
        lk       = ($urandom_range(0, 9) < 7);
        holdLeft = $urandom_range(1, 30);
      end
      holdLeft--;
      rs = ($urandom_range(0, 99) == 0);
      rn = ($urandom_range(0, 299) != 0);
      applyStimulus(rn, rs, lk);
    end

    @(negedge refclk);
    #1;
    checkOutput("scoreboardDrained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_CYCLES, default 16: cycles pll_rst is held high per attempt (1..65535).
REQ-002 Parameter LOCK_TIMEOUT, default 50000: cycles allowed in WAIT_LOCK before the attempt fails (1..65535).
REQ-003 Parameter STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required before release (1..65535).
REQ-004 Parameter MAX_RETRY, default 3: failed attempts that lead to FAULT (1..15).
REQ-005 refclk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 pll_locked  in  1  PLL locked output, asynchronous to refclk.
REQ-008 restart  in  1  one-cycle request to re-sequence the PLL.
REQ-009 pll_rst  out  1  drives the PLL rst input, active-high.
REQ-010 sys_rst_n  out  1  downstream synchronous reset, active-low.
REQ-011 ready  out  1  high only in RUN.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 state  out  3  current FSM state code.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-stage output, lock_s.
REQ-015 State codes SHALL be RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4; a 16-bit cycle counter SHALL be shared and cleared on every state change.
REQ-016 RESET_PLL: pll_rst=1; after RST_CYCLES cycles -> WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE. Counter reaching LOCK_TIMEOUT-1 with lock_s=0 SHALL increment retry_cnt (4-bit), then go to FAULT if the new value equals MAX_RETRY, otherwise to RESET_PLL.
REQ-018 STABLE: lock_s=0 -> WAIT_LOCK (no retry increment); STABLE_CYCLES consecutive cycles with lock_s=1 -> RUN.
REQ-019 Entering RUN SHALL set sys_rst_n=1 and ready=1 on the same edge and clear retry_cnt.
REQ-020 RUN: lock_s=0 -> RESET_PLL; sys_rst_n=0 and ready=0 on that same edge.
REQ-021 FAULT: pll_rst=1, sys_rst_n=0, fault=1; remain until restart=1.
REQ-022 restart=1 in any state SHALL force RESET_PLL with retry_cnt=0 and sys_rst_n=0 on the next edge; restart overrides every other transition in the same cycle.
REQ-023 sys_rst_n SHALL be 1 only in RUN; all outputs SHALL be registered.
REQ-024 sys_rst_n SHALL rise at edge k+2+STABLE_CYCLES, where edge k is the first edge sampling pll_locked=1 in WAIT_LOCK and lock stays high.

Reset
REQ-025 rst_n=0 at an edge SHALL set state=RESET_PLL, counter=0, retry_cnt=0, synchronizer=0, pll_rst=1, sys_rst_n=0, ready=0, fault=0, regardless of state, including mid-RUN.
REQ-026 After rst_n returns high, RESET_PLL SHALL run a full RST_CYCLES count.

Configuration
REQ-027 With macro PLL_SUP_STATUS_EN defined, the block SHALL add output loss_cnt (8-bit), which increments on each RUN->RESET_PLL lock-loss transition, saturates at 255, clears only on rst_n, and is unaffected by restart.
REQ-028 Without PLL_SUP_STATUS_EN, loss_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-029 Bench SHALL cover: reset release, pll_locked=1 from cycle 6 -> pll_rst low for cycles 4..; sys_rst_n=1, ready=1 at edge k+10; state sequence 0,1,2,3.
REQ-030 Bench SHALL cover: pll_locked held 0 -> two 20-cycle timeouts -> state=4, fault=1, pll_rst=1; restart pulse -> state=0, fault=0 next edge.
REQ-031 Bench SHALL cover: in RUN, pll_locked drops for 1 cycle -> sys_rst_n=0 two edges after the drop edge; re-lock -> RUN again; loss_cnt=1 when PLL_SUP_STATUS_EN is defined.
REQ-032 Bench SHALL cover: lock glitch low at STABLE cycle 5 -> return to WAIT_LOCK; retry_cnt unchanged; full 8-cycle count restarts.
REQ-033 Bench SHALL cover: rst_n=0 for one cycle mid-RUN -> all outputs at reset values on that edge; the full sequence then repeats.
REQ-034 Bench SHALL cover: restart asserted in the same cycle the WAIT_LOCK timeout fires on the final retry -> state=0, not 4, with retry_cnt=0.
